// File: rtl/cbrt_pkg.sv
// cbrt_pkg: shared widths and FSM state encoding for the cube-root job controller
package cbrt_pkg;
  localparam int DATA_W = 8;
  localparam int CNT_W = 16;
  typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, HOLD} state_t;
endpackage

// File: rtl/cbrt_fifo.sv
// cbrt_fifo: operand queue with full/empty flags and modulo-wrapping pointers
module cbrt_fifo
  import cbrt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd];
  // pointer, occupancy and storage update; push is refused when full even if popping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wr] <= din;
        wr <= wr + 1'b1;
      end
      if (do_pop) rd <= rd + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/cbrt_job_ctrl.sv
// cbrt_job_ctrl: queues operands and sequences them one at a time through an external cube-root core
module cbrt_job_ctrl
  import cbrt_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_c,
  input  logic              rst_c,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_x,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_x,
  output logic [DATA_W-1:0] out_root,
  input  logic              out_ready,
  output logic              core_start_c,
  output logic [DATA_W-1:0] core_x,
  input  logic              core_busy,
  input  logic [DATA_W-1:0] core_result,
  output logic [CNT_W-1:0]  done_cnt
);
  state_t state, state_d;
  logic full, empty, pop;
  logic [DATA_W-1:0] head;
  cbrt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_c),
    .rst(rst_c),
    .push(in_valid),
    .pop(pop),
    .din(in_x),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign in_ready = !full;
  // next-state and Moore outputs; the core handshake waits for busy to rise then fall
  always_comb begin
    state_d = state;
    pop = state == IDLE && !empty;
    core_start_c = state == START;
    out_valid = state == HOLD;
    state_d = state == IDLE    ? (empty ? IDLE : START) :
              state == START   ? WAIT_HI :
              state == WAIT_HI ? (core_busy ? WAIT_LO : WAIT_HI) :
              state == WAIT_LO ? (core_busy ? WAIT_LO : HOLD) :
                                 (out_ready ? IDLE : HOLD);
  end
  // state register plus operand, result and completion-count capture
  always_ff @(posedge clk_c) begin
    if (rst_c) begin
      state <= IDLE;
      core_x <= '0;
      out_x <= '0;
      out_root <= '0;
      done_cnt <= '0;
    end else begin
      state <= state_d;
      if (pop) begin
        core_x <= head;
        out_x <= head;
      end
      if (state == WAIT_LO && !core_busy) out_root <= core_result;
      if (state == HOLD && out_ready) done_cnt <= done_cnt + 1'b1;
    end
  end
endmodule
